// File: rtl/decoder_2x4_arbiter.sv
// Round-robin arbiter sharing one 2x4 decoder among four requesters.
// The owner index drives the decoder select pair {dec_A,dec_B}, and the
// enable and grant vector come straight from registers. A hold-time limit
// stops one requester from monopolising the decoder while others wait.
module decoder_2x4_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       dec_A,
  output logic       dec_B,
  output logic       dec_en,
  output logic       busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // A MAX_HOLD of zero turns the hold limit off entirely, so the last-cycle
  // constant is only meaningful when preemption is enabled.
  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = PREEMPT_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  logic [0:0] state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] hold_q,  hold_d;
  logic [3:0] gnt_q,   gnt_d;
  logic       en_q,    en_d;

  logic [3:0] otherReq;
  logic [2:0] hit;
  logic       atLimit;

  // Returns {found, index} of the first set bit scanning p, p+1, ... mod 4.
  // Iterating from the farthest position down lets the nearest one win.
  function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Next-state logic: release beats preemption, preemption beats timeout.
  // The owner is masked out of the search so a preempted owner can only
  // win again once the rotating pointer comes back around to it.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    otherReq = req & ~(4'b0001 << owner_q);
    hit      = search((state_q == IDLE) ? req : otherReq, ptr_q);
    atLimit  = PREEMPT_EN && (hold_q == HOLD_LAST);

    case (state_q)
      IDLE: begin
        if (hit[2]) begin
          state_d = GRANT;
          owner_d = hit[1:0];
          ptr_d   = hit[1:0] + 2'd1;
          hold_d  = 8'd0;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          if (hit[2]) begin
            owner_d = hit[1:0];
            ptr_d   = hit[1:0] + 2'd1;
          end else begin
            state_d = IDLE;
          end
          hold_d = 8'd0;
        end else if (atLimit && hit[2]) begin
          owner_d = hit[1:0];
          ptr_d   = hit[1:0] + 2'd1;
          hold_d  = 8'd0;
        end else if (atLimit) begin
          hold_d = 8'd0;
        end else if (PREEMPT_EN) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 8'd0;
      end
    endcase

    gnt_d = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
    en_d  = (state_d == GRANT);
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= 8'd0;
      gnt_q   <= 4'b0000;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
    end
  end

  assign gnt    = gnt_q;
  assign dec_A  = owner_q[1];
  assign dec_B  = owner_q[0];
  assign dec_en = en_q;
  assign busy   = en_q;

endmodule

// File: tb/tb_decoder_2x4_arbiter.sv
// Directed bench for decoder_2x4_arbiter: four instances with different
// hold limits run side by side on a shared clock and reset.
module tb_decoder_2x4_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req8, req2, req0, req4;
  logic [3:0] gnt8, gnt2, gnt0, gnt4;
  logic       a8, b8, en8, busy8;
  logic       a2, b2, en2, busy2;
  logic       a0, b0, en0, busy0;
  logic       a4, b4, en4, busy4;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  decoder_2x4_arbiter #(.MAX_HOLD(8)) u8 (
    .clk(clk), .reset(reset), .req(req8), .gnt(gnt8),
    .dec_A(a8), .dec_B(b8), .dec_en(en8), .busy(busy8));
  decoder_2x4_arbiter #(.MAX_HOLD(2)) u2 (
    .clk(clk), .reset(reset), .req(req2), .gnt(gnt2),
    .dec_A(a2), .dec_B(b2), .dec_en(en2), .busy(busy2));
  decoder_2x4_arbiter #(.MAX_HOLD(0)) u0 (
    .clk(clk), .reset(reset), .req(req0), .gnt(gnt0),
    .dec_A(a0), .dec_B(b0), .dec_en(en0), .busy(busy0));
  decoder_2x4_arbiter #(.MAX_HOLD(4)) u4 (
    .clk(clk), .reset(reset), .req(req4), .gnt(gnt4),
    .dec_A(a4), .dec_B(b4), .dec_en(en4), .busy(busy4));

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances n rising edges and settles 1 time unit past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rrExp [9];
    rrExp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
              4'b0100, 4'b1000, 4'b1000, 4'b0001};

    reset = 1'b1;
    req8 = 4'b0; req2 = 4'b0; req0 = 4'b0; req4 = 4'b0;
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("reset_gnt",  {28'd0, gnt8}, 32'h0);
    checkOutput("reset_en",   {31'd0, en8}, 32'h0);
    checkOutput("reset_busy", {31'd0, busy8}, 32'h0);
    checkOutput("reset_sel",  {30'd0, a8, b8}, 32'h0);

    // Single requester from idle, then release back to idle.
    req8 = 4'b0100;
    applyStimulus(1);
    checkOutput("single_gnt",  {28'd0, gnt8}, 32'h4);
    checkOutput("single_sel",  {30'd0, a8, b8}, 32'h2);
    checkOutput("single_en",   {31'd0, en8}, 32'h1);
    checkOutput("single_busy", {31'd0, busy8}, 32'h1);
    req8 = 4'b0000;
    applyStimulus(1);
    checkOutput("idle_gnt", {28'd0, gnt8}, 32'h0);
    checkOutput("idle_en",  {31'd0, en8}, 32'h0);
    checkOutput("idle_sel_kept", {30'd0, a8, b8}, 32'h2);

    // Asynchronous reset in the middle of a grant to owner 2.
    req8 = 4'b0100;
    applyStimulus(1);
    checkOutput("pre_reset_gnt", {28'd0, gnt8}, 32'h4);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_gnt", {28'd0, gnt8}, 32'h0);
    checkOutput("async_reset_en",  {31'd0, en8}, 32'h0);
    checkOutput("async_reset_sel", {30'd0, a8, b8}, 32'h0);
    req8 = 4'b0000;
    applyStimulus(1);
    reset = 1'b0;
    applyStimulus(2);
    checkOutput("post_reset_idle", {28'd0, gnt8}, 32'h0);
    checkOutput("post_reset_en",   {31'd0, en8}, 32'h0);

    // Release handoff from owner 1 to owner 3 without an idle gap.
    req8 = 4'b0010;
    applyStimulus(1);
    checkOutput("ho_owner1", {28'd0, gnt8}, 32'h2);
    req8 = 4'b0011;
    applyStimulus(1);
    checkOutput("ho_hold1", {28'd0, gnt8}, 32'h2);
    req8 = 4'b1001;
    applyStimulus(1);
    checkOutput("ho_gnt3", {28'd0, gnt8}, 32'h8);
    checkOutput("ho_sel3", {30'd0, a8, b8}, 32'h3);
    checkOutput("ho_en",   {31'd0, en8}, 32'h1);
    req8 = 4'b0000;
    applyStimulus(1);
    checkOutput("ho_idle", {28'd0, gnt8}, 32'h0);

    // Round robin with MAX_HOLD=2 and every requester asking.
    req2 = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("rr_gnt%0d", k), {28'd0, gnt2}, {28'd0, rrExp[k]});
      checkOutput($sformatf("rr_en%0d", k), {31'd0, en2}, 32'h1);
    end
    checkOutput("rr_sel_end", {30'd0, a2, b2}, 32'h0);
    req2 = 4'b0000;

    // Preemption disabled: owner 0 keeps the grant despite a waiting contender.
    req0 = 4'b0001;
    applyStimulus(1);
    checkOutput("nopre_first", {28'd0, gnt0}, 32'h1);
    req0 = 4'b1001;
    for (int k = 0; k < 50; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("nopre_hold%0d", k), {28'd0, gnt0}, 32'h1);
    end
    req0 = 4'b1000;
    applyStimulus(1);
    checkOutput("nopre_handoff", {28'd0, gnt0}, 32'h8);
    checkOutput("nopre_sel",     {30'd0, a0, b0}, 32'h3);
    req0 = 4'b0000;

    // Lone owner never loses the grant at the hold limit.
    req4 = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("lone_gnt%0d", k), {28'd0, gnt4}, 32'h2);
      checkOutput($sformatf("lone_en%0d", k),  {31'd0, en4}, 32'h1);
    end
    req4 = 4'b0000;
    applyStimulus(1);
    checkOutput("lone_release", {28'd0, gnt4}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Watchdog so the run always ends even if the stimulus sequence stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    failCount++;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
